ifid_hazard_ctrl: RTL and testbench
===================================

// Module: ifid_hazard_ctrl
// PURPOSE
//  Pipeline control unit that sequences the IF/ID pipeline register and the PC.
//  Each cycle it decides whether to advance, freeze, bubble or flush, from three inputs:
//  load-use hazards, taken branches/jumps resolved in ID, and instruction- and data-memory wait states.
//  It drives PC write-enable, IF/ID write-enable, IF_Flush (which turns the IF/ID opcode into nop 0x00)
//  and the ID/EX bubble. It also keeps saturating stall/flush statistics and a sticky hang detector.
// PARAMETERS
//  FLUSH_EXTRA  1   extra flush cycles after a redirect, beyond the redirect cycle (0..7)
//  CNT_W        16  width of the statistics counters
//  HANG_LIMIT   255 consecutive freeze cycles before hang_err is set (>=1)
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      synchronous, active-high reset
//  id_opcode     in   6      opcode of the instruction in ID (IF/ID OpCode)
//  id_rs         in   5      rs of the instruction in ID
//  id_rt         in   5      rt of the instruction in ID
//  ex_mem_read   in   1      instruction in EX is a load
//  ex_rt         in   5      destination rt of the instruction in EX
//  redirect      in   1      branch taken or jump resolved in ID this cycle
//  imem_ready    in   1      instruction memory has valid data this cycle
//  dmem_busy     in   1      data memory is stalling the back end
//  pc_write      out  1      PC load enable
//  if_id_write   out  1      IF/ID load enable
//  if_flush      out  1      IF/ID loads nop opcode 0x00
//  id_ex_bubble  out  1      ID/EX loads control zeros
//  stall_cnt     out  CNT_W  saturating count of cycles with pc_write=0
//  flush_cnt     out  CNT_W  saturating count of cycles with if_flush=1
//  hang_err      out  1      sticky; set when the freeze run reaches HANG_LIMIT
// BEHAVIOUR
//  - Control outputs are combinational from state and inputs (Mealy), so they act in the same cycle.
//    Counters, state and hang_err are registered.
//  - While rst=1: pc_write=0, if_id_write=1, if_flush=1, id_ex_bubble=1. Next state is RUN;
//    counters, flush_left, freeze_run and hang_err are cleared. rst mid-FLUSH abandons the remaining flushes.
//  - uses_rt = opcode in {0x00 R-type, 0x04 beq, 0x05 bne, 0x2B sw}.
//  - load_use = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (uses_rt & ex_rt==id_rt)).
//  - States: RUN, FLUSH, MEM_WAIT.
//  - In any state, if dmem_busy=1 -> FREEZE: pc_write=0, if_id_write=0, if_flush=0, id_ex_bubble=0.
//    The next state is MEM_WAIT, except from FLUSH, which stays in FLUSH with flush_left held.
//    FREEZE has highest priority.
//  - In RUN and MEM_WAIT with dmem_busy=0, rules apply in this priority order:
//    1 load_use: pc_write=0, if_id_write=0, id_ex_bubble=1, if_flush=0. Next state RUN.
//      This takes priority over redirect: the branch re-resolves after the stall.
//    2 redirect: pc_write=1, if_id_write=1, if_flush=1.
//      If FLUSH_EXTRA>0, next state FLUSH with flush_left=FLUSH_EXTRA; otherwise next state RUN.
//    3 !imem_ready: pc_write=0, if_id_write=1, if_flush=1 (nop enters ID). Next state RUN.
//    4 otherwise: pc_write=1, if_id_write=1, other outputs 0. Next state RUN.
//  - FLUSH with dmem_busy=0: pc_write=imem_ready, if_id_write=1, if_flush=1, id_ex_bubble=0.
//    redirect and load_use are ignored (ID holds a nop).
//    flush_left decrements only when imem_ready=1; on reaching 0 the next state is RUN.
//  - MEM_WAIT exists only to mark an ongoing freeze; its exit cycle is evaluated exactly as RUN.
//  - Counters: stall_cnt +1 on each non-reset cycle with pc_write=0; flush_cnt +1 on each non-reset
//    cycle with if_flush=1. Both saturate at all-ones and never wrap.
//  - Hang detector: freeze_run (8b, saturating) counts consecutive FREEZE cycles and clears on
//    any non-FREEZE cycle. hang_err is set when freeze_run reaches HANG_LIMIT and clears only on rst.
// STRUCTURE
//  - Shared package pipe_ctrl_pkg holds: the opcode constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_SW,
//    OP_NOP), the state enum {RUN, FLUSH, MEM_WAIT}, and a uses_rt() function.
//  - One sub-module, sat_counter (width param, inc, clr), is instantiated twice for stall_cnt
//    and flush_cnt. The FSM, hazard compare and hang detector stay inline.
// TESTING
//  1 ex_mem_read=1, ex_rt=8, id_opcode=0x00, id_rt=8 -> one cycle with pc_write=0, if_id_write=0,
//    id_ex_bubble=1; stall_cnt=1. Same stimulus with ex_rt=0 -> no stall.
//  2 FLUSH_EXTRA=1, redirect for 1 cycle, imem_ready=1 -> if_flush=1 for 2 cycles, then RUN;
//    flush_cnt=2.
//  3 dmem_busy=1 for 3 cycles together with redirect -> 3 frozen cycles (all outputs 0);
//    the flush starts on cycle 4.
//  4 dmem_busy=1 and load_use in the same cycle -> freeze, not bubble (id_ex_bubble=0).
//    The bubble occurs on the first cycle with dmem_busy=0.
//  5 rst=1 for one cycle mid-FLUSH -> the next cycle is RUN with normal advance;
//    counters and hang_err are 0.
//  6 HANG_LIMIT=4, CNT_W=2, dmem_busy held for 6 cycles -> hang_err rises after the 4th frozen cycle
//    and stays after busy drops; stall_cnt saturates at 3.

Source files
------------

// File: rtl/ifid_hazard_ctrl_pkg.sv
// Shared definitions for the IF/ID hazard controller: opcode constants, FSM state
// encoding and the rt-usage decode.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_NOP   = 6'h00;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Opcodes whose rt field is a source operand (and so can hit a load-use hazard).
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/ifid_hazard_ctrl_if.sv
// Bundle between the IF/ID datapath and the hazard controller: hazard sources in,
// register enables and statistics out.
interface ifid_hazard_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic [5:0]       id_opcode;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             redirect;
    logic             imem_ready;
    logic             dmem_busy;

    logic             pc_write;
    logic             if_id_write;
    logic             if_flush;
    logic             id_ex_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             hang_err;

    modport master (
        output id_opcode, id_rs, id_rt, ex_mem_read, ex_rt, redirect, imem_ready, dmem_busy,
        input  pc_write, if_id_write, if_flush, id_ex_bubble, stall_cnt, flush_cnt, hang_err
    );

    modport slave (
        input  id_opcode, id_rs, id_rt, ex_mem_read, ex_rt, redirect, imem_ready, dmem_busy,
        output pc_write, if_id_write, if_flush, id_ex_bubble, stall_cnt, flush_cnt, hang_err
    );
endinterface

// File: rtl/ifid_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID pipeline sequencer: decides advance / freeze / bubble / flush each cycle and
// keeps stall/flush statistics plus a sticky hang flag.
module ifid_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_EXTRA = 1,
    parameter int CNT_W       = 16,
    parameter int HANG_LIMIT  = 255
) (
    input logic              clk,
    input logic              rst,
    ifid_hazard_ctrl_if.slave hz
);

    state_t     state, state_nxt;
    logic [2:0] flush_left, flush_left_nxt;
    logic [7:0] freeze_run, freeze_run_nxt;
    logic       freeze;
    logic       load_use;
    logic       pc_write, if_id_write, if_flush, id_ex_bubble;

    assign load_use = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                      ((hz.ex_rt == hz.id_rs) || (uses_rt(hz.id_opcode) && (hz.ex_rt == hz.id_rt)));

    always_comb begin
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        if_flush       = 1'b0;
        id_ex_bubble   = 1'b0;
        freeze         = 1'b0;
        state_nxt      = RUN;
        flush_left_nxt = flush_left;

        if (rst) begin
            pc_write       = 1'b0;
            if_flush       = 1'b1;
            id_ex_bubble   = 1'b1;
            flush_left_nxt = 3'd0;
        end else if (hz.dmem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            freeze      = 1'b1;
            state_nxt   = (state == FLUSH) ? FLUSH : MEM_WAIT;
        end else if (state == FLUSH) begin
            // ID already holds a nop here, so redirect/load_use are meaningless.
            pc_write  = hz.imem_ready;
            if_flush  = 1'b1;
            state_nxt = FLUSH;
            if (hz.imem_ready) begin
                if (flush_left <= 3'd1) begin
                    flush_left_nxt = 3'd0;
                    state_nxt      = RUN;
                end else begin
                    flush_left_nxt = flush_left - 3'd1;
                end
            end
        end else if (load_use) begin
            // Branch in ID waits behind the load and re-resolves after the bubble.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (hz.redirect) begin
            if_flush = 1'b1;
            if (FLUSH_EXTRA > 0) begin
                state_nxt      = FLUSH;
                flush_left_nxt = 3'(FLUSH_EXTRA);
            end
        end else if (!hz.imem_ready) begin
            pc_write = 1'b0;
            if_flush = 1'b1;
        end
    end

    assign freeze_run_nxt = !freeze            ? 8'd0 :
                            (freeze_run == 8'hFF) ? freeze_run : freeze_run + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            flush_left <= 3'd0;
            freeze_run <= 8'd0;
            hz.hang_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_left <= flush_left_nxt;
            freeze_run <= freeze_run_nxt;
            if (freeze && (int'(freeze_run_nxt) >= HANG_LIMIT))
                hz.hang_err <= 1'b1;
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.if_id_write  = if_id_write;
    assign hz.if_flush     = if_flush;
    assign hz.id_ex_bubble = id_ex_bubble;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (!pc_write),
        .cnt (hz.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .clr (rst),
        .inc (if_flush),
        .cnt (hz.flush_cnt)
    );

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Directed-vector bench for ifid_hazard_ctrl: default-parameter instance for hazard
// sequencing, small instance (HANG_LIMIT=4, CNT_W=2) for hang and saturation.
module tb_ifid_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    ifid_hazard_ctrl_if #(.CNT_W(16)) h0 ();
    ifid_hazard_ctrl_if #(.CNT_W(2))  h1 ();

    ifid_hazard_ctrl #(.FLUSH_EXTRA(1), .CNT_W(16), .HANG_LIMIT(255)) d0 (
        .clk (clk),
        .rst (rst),
        .hz  (h0)
    );

    ifid_hazard_ctrl #(.FLUSH_EXTRA(1), .CNT_W(2), .HANG_LIMIT(4)) d1 (
        .clk (clk),
        .rst (rst),
        .hz  (h1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        h0.id_opcode = 6'h00; h0.id_rs = 5'd1; h0.id_rt = 5'd2;
        h0.ex_mem_read = 1'b0; h0.ex_rt = 5'd0; h0.redirect = 1'b0;
        h0.imem_ready = 1'b1; h0.dmem_busy = 1'b0;
        h1.id_opcode = 6'h00; h1.id_rs = 5'd1; h1.id_rt = 5'd2;
        h1.ex_mem_read = 1'b0; h1.ex_rt = 5'd0; h1.redirect = 1'b0;
        h1.imem_ready = 1'b1; h1.dmem_busy = 1'b0;
    endtask

    // One cycle on d0: check the combinational controls mid-cycle, then clock.
    task automatic cyc(input string tag, input logic pc, input logic ifid,
                       input logic fl, input logic bub);
        @(negedge clk);
        chk({tag, ".pc_write"},     32'(h0.pc_write),     32'(pc));
        chk({tag, ".if_id_write"},  32'(h0.if_id_write),  32'(ifid));
        chk({tag, ".if_flush"},     32'(h0.if_flush),     32'(fl));
        chk({tag, ".id_ex_bubble"}, 32'(h0.id_ex_bubble), 32'(bub));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc("rst", 1'b0, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        chk("rst.stall_cnt", 32'(h0.stall_cnt), 32'd0);
        chk("rst.flush_cnt", 32'(h0.flush_cnt), 32'd0);
        chk("rst.hang_err",  32'(h0.hang_err),  32'd0);
    endtask

    task automatic cnts(input string tag, input int st, input int fl);
        chk({tag, ".stall_cnt"}, 32'(h0.stall_cnt), 32'(st));
        chk({tag, ".flush_cnt"}, 32'(h0.flush_cnt), 32'(fl));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        do_reset();
        cyc("norm", 1'b1, 1'b1, 1'b0, 1'b0);

        // load-use via rt on R-type, ex_rt=0 guard, lw ignores rt, rs always counts
        h0.ex_mem_read = 1'b1; h0.ex_rt = 5'd8; h0.id_rt = 5'd8; h0.id_opcode = 6'h00;
        cyc("lu_rt", 1'b0, 1'b0, 1'b0, 1'b1);
        cnts("lu_rt", 1, 0);
        h0.ex_rt = 5'd0; h0.id_rt = 5'd0;
        cyc("lu_r0", 1'b1, 1'b1, 1'b0, 1'b0);
        h0.ex_rt = 5'd8; h0.id_rt = 5'd8; h0.id_opcode = 6'h23;
        cyc("lu_lw", 1'b1, 1'b1, 1'b0, 1'b0);
        h0.id_rs = 5'd8;
        cyc("lu_rs", 1'b0, 1'b0, 1'b0, 1'b1);
        cnts("lu_rs", 2, 0);

        // redirect + one extra flush; second redirect with an imem wait inside FLUSH
        do_reset();
        h0.redirect = 1'b1;
        cyc("rd", 1'b1, 1'b1, 1'b1, 1'b0);
        h0.redirect = 1'b0;
        cyc("fl1", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("fl_done", 1'b1, 1'b1, 1'b0, 1'b0);
        cnts("fl_done", 0, 2);
        h0.redirect = 1'b1;
        cyc("rd2", 1'b1, 1'b1, 1'b1, 1'b0);
        h0.imem_ready = 1'b0;
        cyc("fl_wait", 1'b0, 1'b1, 1'b1, 1'b0);
        h0.imem_ready = 1'b1; h0.redirect = 1'b0;
        cyc("fl2", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("norm2", 1'b1, 1'b1, 1'b0, 1'b0);
        cnts("norm2", 1, 5);
        h0.imem_ready = 1'b0;
        cyc("imiss", 1'b0, 1'b1, 1'b1, 1'b0);
        h0.imem_ready = 1'b1;

        // freeze beats redirect; flush starts on the first non-busy cycle
        do_reset();
        h0.dmem_busy = 1'b1; h0.redirect = 1'b1;
        for (int i = 0; i < 3; i++) cyc("frz_rd", 1'b0, 1'b0, 1'b0, 1'b0);
        h0.dmem_busy = 1'b0;
        cyc("rd_after", 1'b1, 1'b1, 1'b1, 1'b0);
        h0.redirect = 1'b0;
        cyc("fl3", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("norm3", 1'b1, 1'b1, 1'b0, 1'b0);
        cnts("norm3", 3, 2);
        // freeze inside FLUSH holds flush_left
        h0.redirect = 1'b1;
        cyc("rd4", 1'b1, 1'b1, 1'b1, 1'b0);
        h0.redirect = 1'b0; h0.dmem_busy = 1'b1;
        cyc("frz_fl", 1'b0, 1'b0, 1'b0, 1'b0);
        h0.dmem_busy = 1'b0;
        cyc("fl4", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("norm4", 1'b1, 1'b1, 1'b0, 1'b0);
        cnts("norm4", 4, 4);

        // freeze beats load-use; bubble follows
        do_reset();
        h0.dmem_busy = 1'b1; h0.ex_mem_read = 1'b1; h0.ex_rt = 5'd8; h0.id_rt = 5'd8;
        cyc("frz_lu", 1'b0, 1'b0, 1'b0, 1'b0);
        h0.dmem_busy = 1'b0;
        cyc("lu_after", 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        cyc("norm5", 1'b1, 1'b1, 1'b0, 1'b0);

        // reset mid-FLUSH abandons remaining flushes
        do_reset();
        h0.redirect = 1'b1;
        cyc("rd6", 1'b1, 1'b1, 1'b1, 1'b0);
        h0.redirect = 1'b0;
        rst = 1'b1;
        cyc("rst_mid", 1'b0, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        cyc("post_rst", 1'b1, 1'b1, 1'b0, 1'b0);
        cnts("post_rst", 0, 0);
        chk("post_rst.hang_err", 32'(h0.hang_err), 32'd0);

        // hang detector and saturation on the small instance
        do_reset();
        h1.dmem_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hang.c%0d.hang_err", i + 1), 32'(h1.hang_err), (i >= 3) ? 32'd1 : 32'd0);
            chk($sformatf("hang.c%0d.stall_cnt", i + 1), 32'(h1.stall_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        h1.dmem_busy = 1'b0;
        @(posedge clk);
        #1;
        chk("hang.after.hang_err", 32'(h1.hang_err), 32'd1);
        chk("hang.after.stall_cnt", 32'(h1.stall_cnt), 32'd3);
        chk("hang.d0_clean", 32'(h0.hang_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
